// File: rtl/mcsi2_pkg.sv
// Shared CSI-2 definitions for the capture path: datatype codes, FSM state codes
// and the beat record carried through the skid FIFO.
package mcsi2_pkg;

    localparam logic [5:0] DT_YUV422_8  = 6'h1E;
    localparam logic [5:0] DT_RAW8      = 6'h2A;
    localparam logic [5:0] DT_RGB888    = 6'h24;
    localparam logic [5:0] DT_LONG_MIN  = 6'h13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_CAP   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic        eof;
        logic        eol;
        logic        sof;
        logic [15:0] pix;
    } beat_t;

    // Only long packets carry payload lines worth capturing.
    function automatic logic dt_match(input logic [5:0] dt, input logic [5:0] cfg);
        return (dt == cfg) && (dt >= DT_LONG_MIN);
    endfunction

endpackage

// File: rtl/mcsi2_skid_fifo.sv
// Small synchronous FIFO absorbing the decoder read latency; reports free entries
// so the read enable can be withheld before the FIFO can overflow.
module mcsi2_skid_fifo #(
    parameter int pDepth = 4,
    parameter int pWidth = 19
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [pWidth-1:0]         din,
    output logic [pWidth-1:0]         dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(pDepth):0]   free
);
    localparam int AW = $clog2(pDepth);
    localparam int CW = AW + 1;

    logic [pWidth-1:0] mem [pDepth];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push, do_pop;

    assign full    = (count == CW'(pDepth));
    assign empty   = (count == '0);
    assign free    = CW'(pDepth) - count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcsi2_frame_capture_ctrl.sv
// Paces decoder reads and frames long-packet payload beats into lines and frames,
// forwarding matching lines with SOF/EOL/EOF markers on a valid/ready stream.
module mcsi2_frame_capture_ctrl
    import mcsi2_pkg::*;
#(
    parameter int pSkidDepth  = 4,
    parameter int pLineCntBit = 12
) (
    input  logic                   iSCLK,
    input  logic                   iSRST,
    input  logic                   iCapEn,
    input  logic [5:0]             iCfgDatatype,
    input  logic [pLineCntBit-1:0] iCfgLines,
    input  logic [31:0]            iHsPixel,
    input  logic [5:0]             iHsDatatype,
    input  logic [15:0]            iHsWordCnt,
    input  logic                   iHsValid,
    input  logic                   iCddFifoFull,
    output logic                   oEdv,
    output logic [15:0]            oPixel,
    output logic                   oSof,
    output logic                   oEol,
    output logic                   oEof,
    output logic                   oVd,
    input  logic                   iRdy,
    output logic                   oBusy,
    output logic [15:0]            oFrameCnt,
    output logic                   oLenErr,
    output logic                   oOvfErr
);
    localparam int CW = $clog2(pSkidDepth) + 1;

    logic [1:0]             state;
    logic [14:0]            beat_cnt, line_len, cur_len;
    logic                   line_cap, sof_pend;
    logic [pLineCntBit-1:0] line_cnt, lines_eff;
    logic                   first, cur_cap, last_beat, eof_beat, cap_beat;
    logic                   push, pop, full, empty;
    logic [CW-1:0]          free;
    beat_t                  push_beat, pop_beat;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, iHsPixel[31:16], iHsWordCnt[0]};
    assign lines_eff = (iCfgLines == '0) ? pLineCntBit'(1) : iCfgLines;
    assign oEdv      = ((state == ST_SYNC) || (state == ST_CAP)) && (free >= CW'(3));
    assign oBusy     = (state != ST_IDLE);

    // Line attributes come live from the decoder on the first beat, from registers afterwards.
    always_comb begin
        first     = (beat_cnt == '0);
        cur_len   = first ? iHsWordCnt[15:1] : line_len;
        cur_cap   = first ? (((state == ST_SYNC) || (state == ST_CAP)) &&
                             dt_match(iHsDatatype, iCfgDatatype) && (iHsWordCnt[15:1] != '0))
                          : line_cap;
        last_beat = (beat_cnt == cur_len - 15'd1);
        eof_beat  = last_beat && (line_cnt >= lines_eff - pLineCntBit'(1));
        cap_beat  = iHsValid && cur_cap;
        push      = cap_beat && !full;
        push_beat = {eof_beat, last_beat, (state == ST_SYNC) || sof_pend, iHsPixel[15:0]};
        pop       = !empty && (!oVd || iRdy);
    end

    mcsi2_skid_fifo #(
        .pDepth (pSkidDepth),
        .pWidth ($bits(beat_t))
    ) u_skid (
        .clk   (iSCLK),
        .rst   (iSRST),
        .push  (push),
        .pop   (pop),
        .din   (push_beat),
        .dout  (pop_beat),
        .full  (full),
        .empty (empty),
        .free  (free)
    );

    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            line_len <= '0;
            line_cap <= 1'b0;
            line_cnt <= '0;
            sof_pend <= 1'b0;
            oLenErr  <= 1'b0;
            oOvfErr  <= 1'b0;
        end else begin
            if (iCddFifoFull && (state != ST_IDLE)) oOvfErr <= 1'b1;
            if (iHsValid) begin
                if (first) begin
                    line_len <= cur_len;
                    line_cap <= cur_cap;
                end
                // A zero-length line is consumed by its single beat; the counter stays at 0.
                if (first && (cur_len == '0)) oLenErr <= 1'b1;
                else if (last_beat)           beat_cnt <= '0;
                else                          beat_cnt <= beat_cnt + 15'd1;
                if (cap_beat && full) oLenErr <= 1'b1;
            end
            case (state)
                ST_IDLE: if (iCapEn) state <= ST_SYNC;
                ST_SYNC, ST_CAP: begin
                    if (cap_beat) begin
                        sof_pend <= 1'b0;
                        state    <= ST_CAP;
                        if (last_beat) begin
                            if (eof_beat) begin
                                line_cnt <= '0;
                                sof_pend <= iCapEn;
                                state    <= iCapEn ? ST_CAP : ST_DRAIN;
                            end else begin
                                line_cnt <= line_cnt + pLineCntBit'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: if (empty) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iSCLK) begin
        if (iSRST) begin
            oVd       <= 1'b0;
            oPixel    <= '0;
            oSof      <= 1'b0;
            oEol      <= 1'b0;
            oEof      <= 1'b0;
            oFrameCnt <= '0;
        end else begin
            if (pop) begin
                oVd                          <= 1'b1;
                {oEof, oEol, oSof, oPixel}   <= pop_beat;
            end else if (iRdy) begin
                oVd <= 1'b0;
            end
            if (oVd && iRdy && oEof) oFrameCnt <= oFrameCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mcsi2_frame_capture_ctrl.sv
// Bench for mcsi2_frame_capture_ctrl: a latency-2 decoder model feeds line lists, and a
// line-level reference model predicts every forwarded beat and its markers.
module tb_mcsi2_frame_capture_ctrl;
    import mcsi2_pkg::*;

    localparam int LB = 12;

    logic          iSCLK = 1'b0;
    logic          iSRST = 1'b1;
    logic          iCapEn = 1'b0;
    logic [5:0]    iCfgDatatype = DT_YUV422_8;
    logic [LB-1:0] iCfgLines = LB'(4);
    logic [31:0]   iHsPixel = '0;
    logic [5:0]    iHsDatatype = '0;
    logic [15:0]   iHsWordCnt = '0;
    logic          iHsValid = 1'b0;
    logic          iCddFifoFull = 1'b0;
    logic          iRdy = 1'b1;
    logic          oEdv, oSof, oEol, oEof, oVd, oBusy, oLenErr, oOvfErr;
    logic [15:0]   oPixel, oFrameCnt;

    always #5 iSCLK = ~iSCLK;

    mcsi2_frame_capture_ctrl #(.pSkidDepth(4), .pLineCntBit(LB)) dut (
        .iSCLK(iSCLK), .iSRST(iSRST), .iCapEn(iCapEn), .iCfgDatatype(iCfgDatatype),
        .iCfgLines(iCfgLines), .iHsPixel(iHsPixel), .iHsDatatype(iHsDatatype),
        .iHsWordCnt(iHsWordCnt), .iHsValid(iHsValid), .iCddFifoFull(iCddFifoFull),
        .oEdv(oEdv), .oPixel(oPixel), .oSof(oSof), .oEol(oEol), .oEof(oEof), .oVd(oVd),
        .iRdy(iRdy), .oBusy(oBusy), .oFrameCnt(oFrameCnt), .oLenErr(oLenErr), .oOvfErr(oOvfErr)
    );

    typedef struct { logic [15:0] pix; logic [5:0] dt; logic [15:0] wc; logic capen; } src_t;

    typedef struct {
        string name;
        int cfg_lines, n_lines, wc, rdy, foreign_idx, zero_idx, drop_idx;
        int exp_beats, exp_sof, exp_eol, exp_eof, exp_frames, exp_lenerr, exp_busy;
    } vec_t;

    src_t        src_q[$];
    logic [18:0] exp_q[$];
    int checks = 0, errors = 0;
    int rdy_mode = 0;
    bit flood = 0, arm = 0;
    int n_beats = 0, n_sof = 0, n_eol = 0, n_eof = 0;
    int m_line = 0, m_frames = 0, m_lines = 4;
    bit m_active = 1, m_lenerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decoder model: a beat appears two cycles after each read enable, while data remains.
    initial begin
        src_t b;
        logic h1, h2, line_capen;
        int cyc;
        h1 = 0; h2 = 0; line_capen = 1; cyc = 0;
        forever begin
            @(posedge iSCLK); #1;
            cyc++;
            if (iSRST) begin
                h1 = 0; h2 = 0; line_capen = 1; iHsValid = 0;
            end else begin
                if ((h2 || flood) && src_q.size() > 0) begin
                    b = src_q.pop_front();
                    iHsValid = 1; iHsPixel = {16'($urandom), b.pix};
                    iHsDatatype = b.dt; iHsWordCnt = b.wc; line_capen = b.capen;
                end else begin
                    iHsValid = 0; iHsPixel = $urandom;
                end
                h2 = h1; h1 = oEdv;
            end
            iCapEn = arm && line_capen;
            case (rdy_mode)
                0: iRdy = 1;
                1: iRdy = (cyc % 3 == 0);
                2: iRdy = 1'($urandom_range(0, 1));
                default: iRdy = 0;
            endcase
        end
    end

    // Output monitor: in-order beat comparison plus hold-while-stalled check.
    initial begin
        logic [18:0] held, e;
        bit held_v;
        held_v = 0;
        forever begin
            @(negedge iSCLK);
            if (iSRST) begin
                held_v = 0; n_beats = 0; n_sof = 0; n_eol = 0; n_eof = 0;
            end else begin
                if (held_v) check("stall_hold", {12'd0, oVd, oPixel, oSof, oEol, oEof}, {12'd0, 1'b1, held});
                if (oVd && iRdy) begin
                    n_beats++; n_sof += int'(oSof); n_eol += int'(oEol); n_eof += int'(oEof);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_beat: got 0x%0h, expected no beat", {oPixel, oSof, oEol, oEof});
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {13'd0, oPixel, oSof, oEol, oEof}, {13'd0, e});
                    end
                    held_v = 0;
                end else if (oVd) begin
                    held_v = 1; held = {oPixel, oSof, oEol, oEof};
                end else begin
                    held_v = 0;
                end
            end
        end
    end

    // Reference model at line granularity.
    task automatic add_line(input logic [5:0] dt, input logic [15:0] wc, input logic capen);
        int nb;
        bit cap;
        logic [15:0] px;
        nb = int'(wc[15:1]);
        cap = m_active && (dt == iCfgDatatype) && (nb > 0);
        if (nb == 0) begin
            if (m_active) m_lenerr = 1;
            src_q.push_back('{16'h0, dt, wc, capen});
        end
        for (int i = 0; i < nb; i++) begin
            px = 16'($urandom);
            src_q.push_back('{px, dt, wc, capen});
            if (cap) exp_q.push_back({px, (m_line == 0 && i == 0), (i == nb - 1),
                                      (i == nb - 1 && m_line == m_lines - 1)});
        end
        if (cap) begin
            m_line++;
            if (m_line == m_lines) begin
                m_line = 0; m_frames++;
                if (!capen) m_active = 0;
            end
        end
    endtask

    task automatic do_reset(input int lines, input bit arm_now);
        arm = 0; flood = 0; rdy_mode = 0; iCddFifoFull = 0; iSRST = 1;
        repeat (3) @(posedge iSCLK);
        #2;
        src_q.delete(); exp_q.delete();
        m_line = 0; m_frames = 0; m_active = 1; m_lenerr = 0;
        iCfgLines = LB'(lines); m_lines = (lines == 0) ? 1 : lines;
        iSRST = 0; arm = arm_now;
    endtask

    task automatic run_until_drained(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() > 0 || oVd) && t < 5000) begin
            @(posedge iSCLK); #2; t++;
        end
        check({tag, "_drain_timeout"}, exp_q.size(), 0);
        repeat (20) @(posedge iSCLK);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_edv"}, oEdv, 0);
        check({tag, "_vd"}, oVd, 0);
        check({tag, "_markers"}, {oSof, oEol, oEof}, 0);
        check({tag, "_pixel"}, oPixel, 0);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_framecnt"}, oFrameCnt, 0);
        check({tag, "_errs"}, {oLenErr, oOvfErr}, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [5:0] dts[3];
        logic [5:0] dt;
        logic [15:0] wc, px;
        int t;
        vec_t v;

        dts[0] = DT_YUV422_8; dts[1] = DT_RAW8; dts[2] = DT_RGB888;
        //          name          L  n  wc rdy frn zro drp beats sof eol eof frm len busy
        vecs[0] = '{"basic",      4, 4, 16, 0, -1, -1, -1, 32, 1, 4, 1, 1, 0, 1};
        vecs[1] = '{"foreign",    4, 5, 16, 0,  2, -1, -1, 32, 1, 4, 1, 1, 0, 1};
        vecs[2] = '{"stall",      4, 8, 16, 1, -1, -1, -1, 64, 2, 8, 2, 2, 0, 1};
        vecs[3] = '{"capen_drop", 4, 8, 16, 2, -1, -1,  1, 32, 1, 4, 1, 1, 0, 0};
        vecs[4] = '{"arm_zero",   2, 4,  6, 0,  0,  1, -1,  6, 1, 2, 1, 1, 1, 1};
        vecs[5] = '{"lines0_odd", 0, 3,  3, 0, -1, -1, -1,  3, 3, 3, 3, 3, 0, 1};

        do_reset(4, 0);
        repeat (3) @(posedge iSCLK);
        #2;
        check_reset_outputs("reset");

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            do_reset(v.cfg_lines, 1);
            rdy_mode = v.rdy;
            for (int l = 0; l < v.n_lines; l++) begin
                dt = (l == v.foreign_idx) ? DT_RAW8 : DT_YUV422_8;
                wc = (l == v.zero_idx) ? 16'd0 : 16'(v.wc);
                add_line(dt, wc, !(v.drop_idx >= 0 && l >= v.drop_idx));
            end
            run_until_drained(v.name);
            check({v.name, "_beats"}, n_beats, v.exp_beats);
            check({v.name, "_sof"}, n_sof, v.exp_sof);
            check({v.name, "_eol"}, n_eol, v.exp_eol);
            check({v.name, "_eof"}, n_eof, v.exp_eof);
            check({v.name, "_frames"}, oFrameCnt, v.exp_frames);
            check({v.name, "_lenerr"}, oLenErr, v.exp_lenerr);
            check({v.name, "_busy"}, oBusy, v.exp_busy);
            check({v.name, "_ovferr"}, oOvfErr, 0);
        end

        // Beats forced in without read enable while the stream is stalled: only 5 fit.
        do_reset(1, 1);
        rdy_mode = 3;
        repeat (4) @(posedge iSCLK);
        #2;
        for (int i = 0; i < 8; i++) begin
            px = 16'($urandom);
            src_q.push_back('{px, DT_YUV422_8, 16'd16, 1'b1});
            if (i < 5) exp_q.push_back({px, (i == 0), 1'b0, 1'b0});
        end
        flood = 1;
        repeat (20) @(posedge iSCLK);
        #2;
        check("flood_lenerr", oLenErr, 1);
        flood = 0; rdy_mode = 0;
        run_until_drained("flood");
        check("flood_beats", n_beats, 5);
        check("flood_frames", oFrameCnt, 0);

        // Decoder FIFO-full pulse mid-capture, then reset mid-frame.
        do_reset(4, 1);
        for (int l = 0; l < 6; l++) add_line(DT_YUV422_8, 16'd16, 1'b1);
        t = 0;
        while (n_beats < 40 && t < 2000) begin
            @(posedge iSCLK); #2; t++;
        end
        check("t5_progress", (n_beats >= 40), 1);
        check("t5_frames", oFrameCnt, 1);
        check("t5_ovf_before", oOvfErr, 0);
        iCddFifoFull = 1;
        @(posedge iSCLK); #2;
        iCddFifoFull = 0;
        repeat (3) @(posedge iSCLK);
        #2;
        check("t5_ovf_set", oOvfErr, 1);
        repeat (10) @(posedge iSCLK);
        #2;
        check("t5_ovf_sticky", oOvfErr, 1);
        do_reset(4, 0);
        check_reset_outputs("t5_reset");
        repeat (10) @(posedge iSCLK);
        #2;
        check("t5_no_eof_after_reset", n_eof, 0);

        // Randomized line mixes against the reference model.
        for (int r = 0; r < 4; r++) begin
            do_reset($urandom_range(0, 4), 1);
            rdy_mode = 2;
            for (int l = 0; l < 12; l++) begin
                dt = dts[$urandom_range(0, 2)];
                wc = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom_range(2, 20));
                add_line(dt, wc, 1'b1);
            end
            run_until_drained("rand");
            check("rand_frames", oFrameCnt, m_frames);
            check("rand_lenerr", oLenErr, m_lenerr);
            check("rand_ovferr", oOvfErr, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
